// File: rtl/frost32_mem_arbiter_pkg.sv
// rtl/frost32_mem_arbiter_pkg.sv - Frost32 CPU package slice: memory port structs and arbiter enums
`ifndef MSB_POS__FROST32_ARB_TIMEOUT_CNT
`define MSB_POS__FROST32_ARB_TIMEOUT_CNT 7
`endif

package PkgFrost32Cpu;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    Dias8   = 2'd0,
    Dias16  = 2'd1,
    Dias32  = 2'd2,
    DiasBad = 2'd3
  } DataInoutAccessSize;

  typedef struct packed {
    logic [31:0]        data;
    logic [31:0]        addr;
    DataInoutAccessType data_inout_access_type;
    DataInoutAccessSize data_inout_access_size;
    logic               req_mem_access;
  } PortOut_Frost32Cpu;

  typedef struct packed {
    logic [31:0] data;
  } PortIn_Frost32Cpu;

  typedef enum logic {
    StArbIdle = 1'b0,
    StArbWait = 1'b1
  } ArbState;

  typedef enum logic {
    ArbPortFetch = 1'b0,
    ArbPortData  = 1'b1
  } ArbPort;

endpackage

// File: rtl/frost32_mem_arb_picker.sv
// rtl/frost32_mem_arb_picker.sv - eligibility mask and tie-break for the two Frost32 memory requesters
// FROST32_MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise the data port wins ties.
module frost32_mem_arb_picker
  import PkgFrost32Cpu::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  input  logic [1:0] ack_mask,
  input  logic       grant_en,
  output logic       grant_valid,
  output ArbPort     grant_port
);

  logic [1:0] eligible;

  // A port acked this cycle may still show its old request; it must not re-win.
  assign eligible    = req_valid & ~ack_mask;
  assign grant_valid = |eligible;

`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
  ArbPort last_port;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_port <= ArbPortData;
    end else if (grant_en && grant_valid) begin
      last_port <= grant_port;
    end
  end

  always_comb begin
    grant_port = ArbPortFetch;
    if (eligible == 2'b11) begin
      grant_port = (last_port == ArbPortData) ? ArbPortFetch : ArbPortData;
    end else if (eligible[1]) begin
      grant_port = ArbPortData;
    end
  end
`else
  logic unused_picker;
  assign unused_picker = &{1'b0, clk, rst_n, grant_en};

  always_comb begin
    grant_port = eligible[1] ? ArbPortData : ArbPortFetch;
  end
`endif

endmodule

// File: rtl/frost32_mem_arbiter.sv
// rtl/frost32_mem_arbiter.sv - shares one memory port between Frost32 fetch (port 0) and data (port 1)
// Optional build macro: FROST32_MEM_ARB_ROUND_ROBIN_EN (round-robin tie-break).
module frost32_mem_arbiter
  import PkgFrost32Cpu::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  PortOut_Frost32Cpu req0_in,
  output PortIn_Frost32Cpu  req0_out,
  output logic              req0_ack,
  output logic              req0_err,
  input  PortOut_Frost32Cpu req1_in,
  output PortIn_Frost32Cpu  req1_out,
  output logic              req1_ack,
  output logic              req1_err,
  output PortOut_Frost32Cpu mem_out,
  input  PortIn_Frost32Cpu  mem_in,
  input  logic              mem_ack,
  output logic              arb_busy
);

  typedef logic [`MSB_POS__FROST32_ARB_TIMEOUT_CNT:0] cnt_t;
  localparam cnt_t TIMEOUT_LIM = cnt_t'(TIMEOUT_CYCLES);

  ArbState           state, state_nxt;
  ArbPort            owner, owner_nxt;
  cnt_t              cnt, cnt_nxt;
  PortOut_Frost32Cpu mem_nxt, win;
  logic [31:0]       resp0_nxt, resp1_nxt, done_data;
  logic [1:0]        ack_nxt, err_nxt;
  logic              done, done_err;
  ArbPort            done_port;
  logic              grant_valid;
  ArbPort            grant_port;

  frost32_mem_arb_picker u_picker (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   ({req1_in.req_mem_access, req0_in.req_mem_access}),
    .ack_mask    ({req1_ack, req0_ack}),
    .grant_en    (state == StArbIdle),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    mem_nxt   = mem_out;
    resp0_nxt = req0_out.data;
    resp1_nxt = req1_out.data;
    ack_nxt   = 2'b00;
    err_nxt   = 2'b00;
    done      = 1'b0;
    done_err  = 1'b0;
    done_data = 32'h0;
    done_port = owner;
    win       = (grant_port == ArbPortData) ? req1_in : req0_in;

    case (state)
      StArbIdle: begin
        if (grant_valid) begin
          if (win.data_inout_access_size == DiasBad) begin
            done      = 1'b1;
            done_err  = 1'b1;
            done_port = grant_port;
          end else begin
            mem_nxt                = win;
            mem_nxt.req_mem_access = 1'b1;
            owner_nxt              = grant_port;
            cnt_nxt                = '0;
            state_nxt              = StArbWait;
          end
        end
      end
      StArbWait: begin
        if (mem_ack) begin
          done                   = 1'b1;
          done_data              = (mem_out.data_inout_access_type == DiatRead) ? mem_in.data : 32'h0;
          mem_nxt.req_mem_access = 1'b0;
          state_nxt              = StArbIdle;
        end else if (cnt == TIMEOUT_LIM) begin
          done                   = 1'b1;
          done_err               = 1'b1;
          mem_nxt.req_mem_access = 1'b0;
          state_nxt              = StArbIdle;
        end else begin
          cnt_nxt = cnt + cnt_t'(1);
        end
      end
      default: state_nxt = StArbIdle;
    endcase

    if (done) begin
      if (done_port == ArbPortData) begin
        ack_nxt[1] = 1'b1;
        err_nxt[1] = done_err;
        resp1_nxt  = done_data;
      end else begin
        ack_nxt[0] = 1'b1;
        err_nxt[0] = done_err;
        resp0_nxt  = done_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StArbIdle;
      owner    <= ArbPortFetch;
      cnt      <= '0;
      mem_out  <= '0;
      req0_out <= '0;
      req1_out <= '0;
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      req0_err <= 1'b0;
      req1_err <= 1'b0;
      arb_busy <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      cnt           <= cnt_nxt;
      mem_out       <= mem_nxt;
      req0_out.data <= resp0_nxt;
      req1_out.data <= resp1_nxt;
      req0_ack      <= ack_nxt[0];
      req1_ack      <= ack_nxt[1];
      req0_err      <= err_nxt[0];
      req1_err      <= err_nxt[1];
      arb_busy      <= (state_nxt == StArbWait);
    end
  end

endmodule

// File: tb/tb_frost32_mem_arbiter.sv
// tb/tb_frost32_mem_arbiter.sv - randomized and directed bench for frost32_mem_arbiter against a transaction model
module tb_frost32_mem_arbiter;
  import PkgFrost32Cpu::*;

  localparam int TMO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  PortOut_Frost32Cpu req0_in, req1_in, mem_out;
  PortIn_Frost32Cpu  req0_out, req1_out, mem_in;
  logic              req0_ack, req0_err, req1_ack, req1_err, mem_ack, arb_busy;

  frost32_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_in(req0_in), .req0_out(req0_out), .req0_ack(req0_ack), .req0_err(req0_err),
    .req1_in(req1_in), .req1_out(req1_out), .req1_ack(req1_ack), .req1_err(req1_err),
    .mem_out(mem_out), .mem_in(mem_in), .mem_ack(mem_ack), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the arbiter has promised to each requester.
  logic              m_busy;
  int                m_owner;
  int                m_last;
  int                m_assert_cyc;
  int                cyc;
  PortOut_Frost32Cpu exp_mem;
  logic [1:0]        exp_ack, exp_err;
  logic [31:0]       exp_out [2];
  logic              exp_busy;

  task automatic check_eq(input string tag, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_owner    = 0;
    m_last     = 1;
    exp_mem    = '0;
    exp_ack    = 2'b00;
    exp_err    = 2'b00;
    exp_out[0] = 32'h0;
    exp_out[1] = 32'h0;
    exp_busy   = 1'b0;
  endtask

  // Predicts the outputs visible after the coming rising edge from the inputs now applied.
  task automatic model_step();
    logic [1:0]        nack, nerr, want;
    int                win;
    PortOut_Frost32Cpu rq;
    nack = 2'b00;
    nerr = 2'b00;
    if (!m_busy) begin
      want[0] = req0_in.req_mem_access && !exp_ack[0];
      want[1] = req1_in.req_mem_access && !exp_ack[1];
      if (want != 2'b00) begin
        if (want == 2'b11) begin
`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
          win = 1 - m_last;
`else
          win = 1;
`endif
        end else begin
          win = want[1] ? 1 : 0;
        end
        m_last = win;
        rq = (win == 1) ? req1_in : req0_in;
        if (rq.data_inout_access_size == DiasBad) begin
          nack[win]    = 1'b1;
          nerr[win]    = 1'b1;
          exp_out[win] = 32'h0;
        end else begin
          m_busy                 = 1'b1;
          m_owner                = win;
          exp_mem                = rq;
          exp_mem.req_mem_access = 1'b1;
          m_assert_cyc           = cyc + 1;
        end
      end
    end else if (mem_ack) begin
      nack[m_owner]          = 1'b1;
      exp_out[m_owner]       = (exp_mem.data_inout_access_type == DiatWrite) ? 32'h0 : mem_in.data;
      exp_mem.req_mem_access = 1'b0;
      m_busy                 = 1'b0;
    end else if (cyc - m_assert_cyc == TMO) begin
      nack[m_owner]          = 1'b1;
      nerr[m_owner]          = 1'b1;
      exp_out[m_owner]       = 32'h0;
      exp_mem.req_mem_access = 1'b0;
      m_busy                 = 1'b0;
    end
    exp_ack  = nack;
    exp_err  = nerr;
    exp_busy = m_busy;
  endtask

  task automatic compare_all();
    check_eq("req0_ack", req0_ack, exp_ack[0]);
    check_eq("req1_ack", req1_ack, exp_ack[1]);
    check_eq("req0_err", req0_err, exp_err[0]);
    check_eq("req1_err", req1_err, exp_err[1]);
    check_eq("req0_out", req0_out.data, exp_out[0]);
    check_eq("req1_out", req1_out.data, exp_out[1]);
    check_eq("mem_out", mem_out, exp_mem);
    check_eq("arb_busy", arb_busy, exp_busy);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  function automatic PortOut_Frost32Cpu rand_req(input bit allow_bad);
    PortOut_Frost32Cpu r;
    r.data                   = $urandom();
    r.addr                   = $urandom();
    r.data_inout_access_type = DataInoutAccessType'($urandom_range(0, 1));
    r.data_inout_access_size = DataInoutAccessSize'($urandom_range(0, 2));
    if (allow_bad && $urandom_range(0, 7) == 0) r.data_inout_access_size = DiasBad;
    r.req_mem_access = 1'b1;
    return r;
  endfunction

  int n, acks0, acks1;

  initial begin
    cyc     = 0;
    req0_in = '0;
    req1_in = '0;
    mem_in  = '0;
    mem_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Port 0 read, memory answers three cycles after the request.
    req0_in = '{data: 32'h0, addr: 32'h100, data_inout_access_type: DiatRead,
                data_inout_access_size: Dias32, req_mem_access: 1'b1};
    cycle();
    check_eq("t1_mem_req", mem_out.req_mem_access, 1'b1);
    cycle();
    cycle();
    mem_ack = 1'b1;
    mem_in.data = 32'hDEADBEEF;
    cycle();
    check_eq("t1_ack0", req0_ack, 1'b1);
    check_eq("t1_data0", req0_out.data, 32'hDEADBEEF);
    check_eq("t1_err0", req0_err, 1'b0);
    check_eq("t1_ack1", req1_ack, 1'b0);
    req0_in.req_mem_access = 1'b0;
    mem_ack = 1'b0;
    cycle();
    cycle();

    // DiasBad write on port 1 never reaches memory.
    req1_in = '{data: 32'h55AA, addr: 32'h200, data_inout_access_type: DiatWrite,
                data_inout_access_size: DiasBad, req_mem_access: 1'b1};
    cycle();
    check_eq("t3_ack1", req1_ack, 1'b1);
    check_eq("t3_err1", req1_err, 1'b1);
    check_eq("t3_mem_req", mem_out.req_mem_access, 1'b0);
    req1_in.req_mem_access = 1'b0;
    cycle();
    check_eq("t3_mem_req_after", mem_out.req_mem_access, 1'b0);

    // Timeout: no memory ack at all.
    req1_in = '{data: 32'h0, addr: 32'h300, data_inout_access_type: DiatRead,
                data_inout_access_size: Dias16, req_mem_access: 1'b1};
    cycle();
    check_eq("t4_mem_req", mem_out.req_mem_access, 1'b1);
    n = 0;
    while (!req1_ack && n < 10) begin
      cycle();
      n++;
    end
    check_eq("t4_latency", n, TMO + 1);
    check_eq("t4_err1", req1_err, 1'b1);
    check_eq("t4_data1", req1_out.data, 32'h0);
    req1_in.req_mem_access = 1'b0;
    cycle();
    check_eq("t4_busy_drop", arb_busy, 1'b0);

    // Both ports held with an always-ready memory.
    req0_in = '{data: 32'h0, addr: 32'hA000, data_inout_access_type: DiatRead,
                data_inout_access_size: Dias32, req_mem_access: 1'b1};
    req1_in = '{data: 32'h0, addr: 32'hB000, data_inout_access_type: DiatRead,
                data_inout_access_size: Dias32, req_mem_access: 1'b1};
    mem_ack = 1'b1;
    cycle();
`ifdef FROST32_MEM_ARB_ROUND_ROBIN_EN
    check_eq("t2_first_grant", mem_out.addr, 32'hA000);
`else
    check_eq("t2_first_grant", mem_out.addr, 32'hB000);
`endif
    acks0 = 0;
    acks1 = 0;
    for (int i = 0; i < 8; i++) begin
      mem_in.data = $urandom();
      cycle();
      acks0 += int'(req0_ack);
      acks1 += int'(req1_ack);
    end
    check_eq("t2_acks_total", acks0 + acks1, 4);
    req0_in.req_mem_access = 1'b0;
    req1_in.req_mem_access = 1'b0;
    repeat (3) cycle();
    mem_ack = 1'b0;
    cycle();

    // Asynchronous reset in the middle of a transaction.
    req0_in = rand_req(1'b0);
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    req0_in.req_mem_access = 1'b0;
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    req0_in = '{data: 32'h0, addr: 32'h400, data_inout_access_type: DiatRead,
                data_inout_access_size: Dias8, req_mem_access: 1'b1};
    cycle();
    check_eq("t5_no_stale_ack", req0_ack, 1'b0);
    mem_ack = 1'b1;
    mem_in.data = 32'h12345678;
    cycle();
    check_eq("t5_ack0", req0_ack, 1'b1);
    check_eq("t5_data0", req0_out.data, 32'h12345678);
    req0_in.req_mem_access = 1'b0;
    mem_ack = 1'b0;
    cycle();

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      if (exp_ack[0]) begin
        case ($urandom_range(0, 2))
          0: req0_in.req_mem_access = 1'b0;
          1: req0_in = rand_req(1'b1);
          default: ;
        endcase
      end else if (!req0_in.req_mem_access && $urandom_range(0, 2) == 0) begin
        req0_in = rand_req(1'b1);
      end
      if (exp_ack[1]) begin
        case ($urandom_range(0, 2))
          0: req1_in.req_mem_access = 1'b0;
          1: req1_in = rand_req(1'b1);
          default: ;
        endcase
      end else if (!req1_in.req_mem_access && $urandom_range(0, 2) == 0) begin
        req1_in = rand_req(1'b1);
      end
      mem_ack = ((i / 100) % 4 == 3) ? 1'b0 : ($urandom_range(0, 2) == 0);
      mem_in.data = $urandom();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
